// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the keypad entry front end.
//   Key code constants, opcode encoding, the entry FSM state enum,
//   the default operand digit count, operand/result widths and small
//   decode helpers used by keypad_entry.
package calc_pkg;

  // Default number of decimal digits accepted per operand
  localparam int MAX_DIGITS_DEF = 4;

  // Operand holds 0..9999 in binary; result holds 9999*9999
  localparam int OPERAND_W   = 14;
  localparam int RESULT_W    = 27;
  localparam int OPERAND_MAX = 9999;

  // Key codes from the scanner; 0..9 are plain digits
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_SET  = 3'd1,
    ENTER_B = 3'd2,
    REQ     = 3'd3,
    WAIT    = 3'd4,
    SHOW    = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys 10..13 map onto opcodes 0..3; adding 2 to the low two
  // bits of the key code gives that mapping without a subtractor.
  function automatic opcode_t key_to_opcode(input logic [3:0] k);
    logic [1:0] low;
    low = k[1:0] + 2'd2;
    return opcode_t'(low);
  endfunction

  // Decimal shift-in: value*10 + digit. Callers only use this while fewer
  // than MAX_DIGITS digits are held, so the result always fits.
  function automatic logic [OPERAND_W-1:0] append_digit(
    input logic [OPERAND_W-1:0] value,
    input logic [3:0]           d
  );
    logic [OPERAND_W+3:0] wide;
    wide = ({4'd0, value} * 18'd10) + {14'd0, d};
    return wide[OPERAND_W-1:0];
  endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: turns the scanner's key-held level into a one-cycle event.
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   push     in   key-held level from the scanner
//   digit    in   key code, valid while push is high
//   key_evt  out  high on the first cycle push is seen high after low
//   key_code out  key code sampled in the key_evt cycle
module key_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] digit,
  output logic       key_evt,
  output logic [3:0] key_code
);

  logic push_q;

  // Push history resets to 1 so a key still held through reset looks
  // already seen and must be released and pressed again to count.
  always_ff @(posedge clock) begin
    if (reset) begin
      push_q <= 1'b1;
    end else begin
      push_q <= push;
    end
  end

  assign key_evt  = push & ~push_q;
  assign key_code = digit;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad front end for a four-function calculator.
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   digit        in   key code from the scanner (0-9 digits, 10-13 ops,
//                     14 equals, 15 clear)
//   push         in   key-held level from the scanner
//   operand_a    out  first operand, binary
//   operand_b    out  second operand, binary
//   opcode       out  0 add, 1 sub, 2 mul, 3 div
//   calc_valid   out  request to the arithmetic unit
//   calc_ready   in   arithmetic unit accepts the request
//   result_valid in   one-cycle strobe qualifying result_in
//   result_in    in   unsigned result from the arithmetic unit
//   disp_value   out  current entry or last result for the display
//   ovf          out  last result exceeded 9999; chaining blocked
module keypad_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           digit,
  input  logic                 push,
  output logic [OPERAND_W-1:0] operand_a,
  output logic [OPERAND_W-1:0] operand_b,
  output logic [1:0]           opcode,
  output logic                 calc_valid,
  input  logic                 calc_ready,
  input  logic                 result_valid,
  input  logic [RESULT_W-1:0]  result_in,
  output logic [RESULT_W-1:0]  disp_value,
  output logic                 ovf
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] operand_a_q, operand_b_q;
  opcode_t              opcode_q;
  logic [CNT_W-1:0]     count_a_q, count_b_q;
  logic [RESULT_W-1:0]  result_q;
  logic                 ovf_q;

  logic       key_evt;
  logic [3:0] key_code;
  logic       evt_digit, evt_op, evt_eq, evt_clr;
  logic       clear_all;

  key_edge u_key_edge (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .digit    (digit),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  assign evt_digit = key_evt && is_digit(key_code);
  assign evt_op    = key_evt && is_operator(key_code);
  assign evt_eq    = key_evt && (key_code == KEY_EQ);
  assign evt_clr   = key_evt && (key_code == KEY_CLR);

  // Clear is honoured everywhere except while a calculation is in flight
  assign clear_all = evt_clr && (state_q != REQ) && (state_q != WAIT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; REQ and WAIT ignore every key so the request stays
  // coherent with the arithmetic unit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTER_A: begin
        if (clear_all)   state_d = ENTER_A;
        else if (evt_op) state_d = OP_SET;
      end
      OP_SET: begin
        if (clear_all)      state_d = ENTER_A;
        else if (evt_digit) state_d = ENTER_B;
      end
      ENTER_B: begin
        if (clear_all)   state_d = ENTER_A;
        else if (evt_eq) state_d = REQ;
      end
      REQ: begin
        if (calc_ready) state_d = WAIT;
      end
      WAIT: begin
        if (result_valid) state_d = SHOW;
      end
      SHOW: begin
        if (clear_all)               state_d = ENTER_A;
        else if (evt_digit)          state_d = ENTER_A;
        else if (evt_op && !ovf_q)   state_d = OP_SET;
      end
      default: state_d = ENTER_A;
    endcase
  end

  // Operand, opcode, digit count and result registers. Nothing changes in
  // REQ, which keeps the request stable until the handshake completes.
  always_ff @(posedge clock) begin
    if (reset || clear_all) begin
      operand_a_q <= '0;
      operand_b_q <= '0;
      opcode_q    <= OP_ADD;
      count_a_q   <= '0;
      count_b_q   <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (evt_digit && (count_a_q < CNT_MAX)) begin
            operand_a_q <= append_digit(operand_a_q, key_code);
            count_a_q   <= count_a_q + CNT_ONE;
          end else if (evt_op) begin
            opcode_q <= key_to_opcode(key_code);
          end
        end
        OP_SET: begin
          if (evt_op) begin
            opcode_q <= key_to_opcode(key_code);
          end else if (evt_digit) begin
            operand_b_q <= append_digit('0, key_code);
            count_b_q   <= CNT_ONE;
          end
        end
        ENTER_B: begin
          if (evt_digit && (count_b_q < CNT_MAX)) begin
            operand_b_q <= append_digit(operand_b_q, key_code);
            count_b_q   <= count_b_q + CNT_ONE;
          end
        end
        WAIT: begin
          if (result_valid) begin
            result_q <= result_in;
            ovf_q    <= (result_in > RESULT_W'(OPERAND_MAX));
          end
        end
        SHOW: begin
          if (evt_digit) begin
            operand_a_q <= append_digit('0, key_code);
            operand_b_q <= '0;
            count_a_q   <= CNT_ONE;
            count_b_q   <= '0;
            ovf_q       <= 1'b0;
          end else if (evt_op && !ovf_q) begin
            // Chain: the previous result becomes the first operand
            operand_a_q <= result_q[OPERAND_W-1:0];
            opcode_q    <= key_to_opcode(key_code);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: request flag and display source follow the state
  always_comb begin
    calc_valid = (state_q == REQ);
    case (state_q)
      ENTER_A, OP_SET:    disp_value = RESULT_W'(operand_a_q);
      ENTER_B, REQ, WAIT: disp_value = RESULT_W'(operand_b_q);
      SHOW:               disp_value = result_q;
      default:            disp_value = '0;
    endcase
  end

  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign opcode    = opcode_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed, table-driven bench for keypad_entry.
module tb_keypad_entry;

  localparam logic [1:0] ACT_KEY = 2'd0;
  localparam logic [1:0] ACT_RDY = 2'd1;
  localparam logic [1:0] ACT_RES = 2'd2;

  typedef struct {
    logic [1:0]  act;
    logic [3:0]  code;
    logic [26:0] res;
    logic [13:0] expA;
    logic [13:0] expB;
    logic [1:0]  expOp;
    logic        expCv;
    logic [26:0] expDisp;
    logic        expOvf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit = 4'd0;
  logic        push = 1'b0;
  logic [13:0] operandA, operandB;
  logic [1:0]  opcode;
  logic        calcValid;
  logic        calcReady = 1'b0;
  logic        resultValid = 1'b0;
  logic [26:0] resultIn = '0;
  logic [26:0] dispValue;
  logic        ovf;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  keypad_entry dut (
    .clock        (clock),
    .reset        (reset),
    .digit        (digit),
    .push         (push),
    .operand_a    (operandA),
    .operand_b    (operandB),
    .opcode       (opcode),
    .calc_valid   (calcValid),
    .calc_ready   (calcReady),
    .result_valid (resultValid),
    .result_in    (resultIn),
    .disp_value   (dispValue),
    .ovf          (ovf)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [1:0] act, input logic [3:0] code, input logic [26:0] res,
                        input logic [13:0] a, input logic [13:0] b, input logic [1:0] op,
                        input logic cv, input logic [26:0] disp, input logic ov);
    vec_t v;
    v.act = act; v.code = code; v.res = res;
    v.expA = a; v.expB = b; v.expOp = op; v.expCv = cv; v.expDisp = disp; v.expOvf = ov;
    vecs.push_back(v);
  endtask

  task automatic pressKey(input logic [3:0] code);
    push = 1'b1;
    digit = code;
    tick();
    tick();
    push = 1'b0;
    tick();
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.act)
      ACT_KEY: pressKey(v.code);
      ACT_RDY: begin
        calcReady = 1'b1;
        tick();
        calcReady = 1'b0;
        tick();
      end
      default: begin
        resultValid = 1'b1;
        resultIn = v.res;
        tick();
        resultValid = 1'b0;
        tick();
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] a, input logic [13:0] b,
                             input logic [1:0] op, input logic cv, input logic [26:0] disp,
                             input logic ov);
    @(negedge clock);
    chk({tag, ".operand_a"}, 27'(operandA), 27'(a));
    chk({tag, ".operand_b"}, 27'(operandB), 27'(b));
    chk({tag, ".opcode"}, 27'(opcode), 27'(op));
    chk({tag, ".calc_valid"}, 27'(calcValid), 27'(cv));
    chk({tag, ".disp_value"}, dispValue, disp);
    chk({tag, ".ovf"}, 27'(ovf), 27'(ov));
  endtask

  // Request must stay put while the arithmetic unit holds calc_ready low
  task automatic holdReadyLow();
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("hold%0d", c), 14'd123, 14'd45, 2'd0, 1'b1, 27'd45, 1'b0);
    end
  endtask

  initial begin
    // Sequence: operand entry, handshake, chaining, overflow, clear,
    // digit limit, leading zeros, new entry from SHOW, stray result strobe
    addVec(ACT_KEY, 4'd1,  0, 1,   0, 0, 0, 1,   0);
    addVec(ACT_KEY, 4'd2,  0, 12,  0, 0, 0, 12,  0);
    addVec(ACT_KEY, 4'd3,  0, 123, 0, 0, 0, 123, 0);
    addVec(ACT_KEY, 4'd10, 0, 123, 0, 0, 0, 123, 0);
    addVec(ACT_KEY, 4'd4,  0, 123, 4, 0, 0, 4,   0);
    addVec(ACT_KEY, 4'd5,  0, 123, 45, 0, 0, 45, 0);
    addVec(ACT_KEY, 4'd11, 0, 123, 45, 0, 0, 45, 0);
    addVec(ACT_KEY, 4'd14, 0, 123, 45, 0, 1, 45, 0);
    addVec(ACT_KEY, 4'd15, 0, 123, 45, 0, 1, 45, 0);
    addVec(ACT_RDY, 4'd0,  0, 123, 45, 0, 0, 45, 0);
    addVec(ACT_KEY, 4'd3,  0, 123, 45, 0, 0, 45, 0);
    addVec(ACT_RES, 4'd0,  168, 123, 45, 0, 0, 168, 0);
    addVec(ACT_KEY, 4'd11, 0, 168, 45, 1, 0, 168, 0);
    addVec(ACT_KEY, 4'd12, 0, 168, 45, 2, 0, 168, 0);
    addVec(ACT_KEY, 4'd11, 0, 168, 45, 1, 0, 168, 0);
    addVec(ACT_KEY, 4'd14, 0, 168, 45, 1, 0, 168, 0);
    addVec(ACT_KEY, 4'd8,  0, 168, 8, 1, 0, 8, 0);
    addVec(ACT_KEY, 4'd14, 0, 168, 8, 1, 1, 8, 0);
    addVec(ACT_RDY, 4'd0,  0, 168, 8, 1, 0, 8, 0);
    addVec(ACT_RES, 4'd0,  27'd99980001, 168, 8, 1, 0, 27'd99980001, 1);
    addVec(ACT_KEY, 4'd10, 0, 168, 8, 1, 0, 27'd99980001, 1);
    addVec(ACT_KEY, 4'd14, 0, 168, 8, 1, 0, 27'd99980001, 1);
    addVec(ACT_KEY, 4'd15, 0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd9,  0, 9,    0, 0, 0, 9,    0);
    addVec(ACT_KEY, 4'd9,  0, 99,   0, 0, 0, 99,   0);
    addVec(ACT_KEY, 4'd9,  0, 999,  0, 0, 0, 999,  0);
    addVec(ACT_KEY, 4'd9,  0, 9999, 0, 0, 0, 9999, 0);
    addVec(ACT_KEY, 4'd9,  0, 9999, 0, 0, 0, 9999, 0);
    addVec(ACT_KEY, 4'd13, 0, 9999, 0, 3, 0, 9999, 0);
    addVec(ACT_KEY, 4'd15, 0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd0,  0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd0,  0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd0,  0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd0,  0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd5,  0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd10, 0, 0, 0, 0, 0, 0, 0);
    addVec(ACT_KEY, 4'd2,  0, 0, 2, 0, 0, 2, 0);
    addVec(ACT_KEY, 4'd14, 0, 0, 2, 0, 1, 2, 0);
    addVec(ACT_RDY, 4'd0,  0, 0, 2, 0, 0, 2, 0);
    addVec(ACT_RES, 4'd0,  2, 0, 2, 0, 0, 2, 0);
    addVec(ACT_KEY, 4'd6,  0, 6, 0, 0, 0, 6, 0);
    addVec(ACT_RES, 4'd0,  555, 6, 0, 0, 0, 6, 0);

    // Reset state
    repeat (3) tick();
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (i == 9) holdReadyLow();
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB, vecs[i].expOp,
                  vecs[i].expCv, vecs[i].expDisp, vecs[i].expOvf);
    end

    // A long hold yields a single digit event
    pressKey(4'd15);
    push = 1'b1;
    digit = 4'd7;
    repeat (20) tick();
    checkOutput("hold20", 7, 0, 0, 0, 7, 0);
    push = 1'b0;
    tick();
    tick();
    checkOutput("release", 7, 0, 0, 0, 7, 0);

    // Reset while a key is held: no event until release and re-press
    push = 1'b1;
    tick();
    checkOutput("press77", 77, 0, 0, 0, 77, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("heldAfterReset", 0, 0, 0, 0, 0, 0);
    push = 1'b0;
    tick();
    tick();
    checkOutput("releasedAfterReset", 0, 0, 0, 0, 0, 0);
    pressKey(4'd7);
    checkOutput("repress", 7, 0, 0, 0, 7, 0);

    // Reset in the middle of a request drops calc_valid next cycle
    pressKey(4'd10);
    pressKey(4'd3);
    pressKey(4'd14);
    checkOutput("reqBeforeReset", 7, 3, 0, 1, 3, 0);
    reset = 1'b1;
    tick();
    checkOutput("reqReset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
